// File: rtl/output_arbiter_if.sv
// ============================================================================
// output_arbiter_if
//   Requester-side bus of the output-register arbiter.
//   Revision: 1.0
// ============================================================================
`default_nettype none

interface output_arbiter_if #(
    parameter int WORD_W = 8,
    parameter int N_REQ  = 2
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ*WORD_W-1:0] wdata_in;
    logic [N_REQ-1:0]        ack;
    logic                    WE;
    logic [WORD_W-1:0]       Wdata;
    logic                    busy;

    modport master (output req, wdata_in, input ack, WE, Wdata, busy);
    modport slave  (input req, wdata_in, output ack, WE, Wdata, busy);
endinterface

`default_nettype wire

// File: rtl/output_arbiter.sv
// ============================================================================
// output_arbiter
//   Round-robin sharing of the output register with a post-write hold period.
//   Define OUTARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module output_arbiter #(
    parameter int WORD_W      = 8,
    parameter int N_REQ       = 2,
    parameter int HOLD_CYCLES = 4
) (
    input  logic            clock,
    input  logic            reset,
    output_arbiter_if.slave bus
);
    localparam int         c_ptr_w     = $clog2(N_REQ);
    localparam logic [7:0] c_hold_load = (HOLD_CYCLES > 0) ? 8'(HOLD_CYCLES - 1) : 8'd0;

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_write = 2'd1;
    localparam logic [1:0] c_hold  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [7:0]         r_cnt;
    logic [c_ptr_w-1:0] r_winner;
    logic [c_ptr_w-1:0] w_sel;
    logic               w_found;
    logic [WORD_W-1:0]  r_data;
    logic [N_REQ-1:0]   w_ack;
    logic [WORD_W-1:0]  w_slot [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign w_slot[gi] = bus.wdata_in[gi*WORD_W +: WORD_W];
    end

`ifdef OUTARB_FIXED_PRIO_EN
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!w_found && bus.req[k]) begin
                w_found = 1'b1;
                w_sel   = c_ptr_w'(k);
            end
        end
    end
`else
    logic [c_ptr_w-1:0] r_ptr;
    logic [c_ptr_w-1:0] w_cand;
    int                 w_idx;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (r_state == c_write) begin
            r_ptr <= (r_winner == c_ptr_w'(N_REQ - 1)) ? '0 : r_winner + c_ptr_w'(1);
        end
    end

    // Search upward from the pointer, wrapping past the last requester.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = 0;
        w_cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx  = (int'(r_ptr) + k) % N_REQ;
            w_cand = c_ptr_w'(w_idx);
            if (!w_found && bus.req[w_cand]) begin
                w_found = 1'b1;
                w_sel   = w_cand;
            end
        end
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle:  if (w_found) w_state_nxt = c_write;
            c_write: w_state_nxt = (HOLD_CYCLES > 0) ? c_hold : c_idle;
            c_hold:  if (r_cnt == 8'd0) w_state_nxt = c_idle;
            default: w_state_nxt = c_idle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= c_idle;
            r_cnt    <= 8'd0;
            r_winner <= '0;
            r_data   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == c_idle && w_found) begin
                r_winner <= w_sel;
                r_data   <= w_slot[w_sel];
            end
            if (r_state == c_write) begin
                r_cnt <= c_hold_load;
            end else if (r_state == c_hold && r_cnt != 8'd0) begin
                r_cnt <= r_cnt - 8'd1;
            end
        end
    end

    always_comb begin
        w_ack = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_ack[k] = (r_state == c_write) && (r_winner == c_ptr_w'(k));
        end
    end

    // Latched data doubles as Wdata: it only changes on a grant, so it
    // holds the last written value outside WRITE.
    assign bus.WE    = (r_state == c_write);
    assign bus.ack   = w_ack;
    assign bus.Wdata = r_data;
    assign bus.busy  = (r_state != c_idle);

endmodule

`default_nettype wire

// File: tb/tb_output_arbiter.sv
// ============================================================================
// tb_output_arbiter
//   Directed checks of the output arbiter on three configurations.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module tb_output_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clock = ~clock;

    output_arbiter_if #(.WORD_W(8), .N_REQ(2)) ifa ();
    output_arbiter_if #(.WORD_W(8), .N_REQ(2)) ifb ();
    output_arbiter_if #(.WORD_W(8), .N_REQ(4)) ifc ();

    output_arbiter #(.WORD_W(8), .N_REQ(2), .HOLD_CYCLES(4)) dut_a (
        .clock(clock), .reset(reset), .bus(ifa));
    output_arbiter #(.WORD_W(8), .N_REQ(2), .HOLD_CYCLES(0)) dut_b (
        .clock(clock), .reset(reset), .bus(ifb));
    output_arbiter #(.WORD_W(8), .N_REQ(4), .HOLD_CYCLES(1)) dut_c (
        .clock(clock), .reset(reset), .bus(ifc));

    typedef struct {
        logic [1:0] req;
        logic [7:0] wd0;
        logic       ewe;
        logic [1:0] eack;
        logic [7:0] ewd;
        logic       ebusy;
    } vec_t;

    vec_t vb [15];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag,
                           input logic we, input logic [3:0] ack, input logic [7:0] wd, input logic busy,
                           input logic ewe, input logic [3:0] eack, input logic [7:0] ewd, input logic ebusy);
        chk({tag, " WE"},    {7'd0, we},   {7'd0, ewe});
        chk({tag, " ack"},   {4'd0, ack},  {4'd0, eack});
        chk({tag, " Wdata"}, wd,           ewd);
        chk({tag, " busy"},  {7'd0, busy}, {7'd0, ebusy});
    endtask

    task automatic exp_a(input string tag, input logic we, input logic [1:0] ack,
                         input logic [7:0] wd, input logic busy);
        chk_out(tag, ifa.WE, {2'b00, ifa.ack}, ifa.Wdata, ifa.busy, we, {2'b00, ack}, wd, busy);
    endtask

    task automatic exp_c(input string tag, input logic we, input logic [3:0] ack,
                         input logic [7:0] wd, input logic busy);
        chk_out(tag, ifc.WE, ifc.ack, ifc.Wdata, ifc.busy, we, ack, wd, busy);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] g1_ack, g2_ack, g3_ack, after1;
        logic [7:0] g1_wd, g2_wd, g3_wd;

        // Contention on a 2-requester, no-hold arbiter, then a drop/re-raise stream.
        vb[0]  = '{2'b11, 8'h11, 1'b0, 2'b00, 8'h00, 1'b0};
        vb[1]  = '{2'b11, 8'h11, 1'b1, 2'b01, 8'h11, 1'b1};
        vb[2]  = '{2'b11, 8'h11, 1'b0, 2'b00, 8'h11, 1'b0};
`ifdef OUTARB_FIXED_PRIO_EN
        vb[3]  = '{2'b11, 8'h11, 1'b1, 2'b01, 8'h11, 1'b1};
        vb[4]  = '{2'b11, 8'h11, 1'b0, 2'b00, 8'h11, 1'b0};
`else
        vb[3]  = '{2'b11, 8'h11, 1'b1, 2'b10, 8'h22, 1'b1};
        vb[4]  = '{2'b11, 8'h11, 1'b0, 2'b00, 8'h22, 1'b0};
`endif
        vb[5]  = '{2'b11, 8'h11, 1'b1, 2'b01, 8'h11, 1'b1};
        vb[6]  = '{2'b11, 8'h11, 1'b0, 2'b00, 8'h11, 1'b0};
`ifdef OUTARB_FIXED_PRIO_EN
        vb[7]  = '{2'b00, 8'h11, 1'b1, 2'b01, 8'h11, 1'b1};
        vb[8]  = '{2'b01, 8'h44, 1'b0, 2'b00, 8'h11, 1'b0};
`else
        vb[7]  = '{2'b00, 8'h11, 1'b1, 2'b10, 8'h22, 1'b1};
        vb[8]  = '{2'b01, 8'h44, 1'b0, 2'b00, 8'h22, 1'b0};
`endif
        vb[9]  = '{2'b00, 8'h44, 1'b1, 2'b01, 8'h44, 1'b1};
        vb[10] = '{2'b01, 8'h55, 1'b0, 2'b00, 8'h44, 1'b0};
        vb[11] = '{2'b00, 8'h55, 1'b1, 2'b01, 8'h55, 1'b1};
        vb[12] = '{2'b01, 8'h66, 1'b0, 2'b00, 8'h55, 1'b0};
        vb[13] = '{2'b00, 8'h66, 1'b1, 2'b01, 8'h66, 1'b1};
        vb[14] = '{2'b00, 8'h66, 1'b0, 2'b00, 8'h66, 1'b0};

`ifdef OUTARB_FIXED_PRIO_EN
        g1_ack = 4'b0001; g1_wd = 8'hC0; after1 = 4'b1000;
        g2_ack = 4'b1000; g2_wd = 8'hC3;
        g3_ack = 4'b0001; g3_wd = 8'hC0;
`else
        g1_ack = 4'b1000; g1_wd = 8'hC3; after1 = 4'b0001;
        g2_ack = 4'b0001; g2_wd = 8'hC0;
        g3_ack = 4'b0010; g3_wd = 8'hC1;
`endif

        ifa.req = 2'b11; ifa.wdata_in = {8'h77, 8'h3C};
        ifb.req = 2'b00; ifb.wdata_in = {8'h22, 8'h11};
        ifc.req = 4'b0000; ifc.wdata_in = {8'hC3, 8'hC2, 8'hC1, 8'hC0};

        // Reset held two cycles with both requests up.
        reset = 1'b1;
        repeat (2) begin
            step(); exp_a("reset", 1'b0, 2'b00, 8'h00, 1'b0);
        end
        reset = 1'b0;

        step(); exp_a("first_grant", 1'b1, 2'b01, 8'h3C, 1'b1); ifa.req = 2'b10;
        for (int i = 0; i < 4; i++) begin
            step(); exp_a("hold1", 1'b0, 2'b00, 8'h3C, 1'b1);
        end
        step(); exp_a("idle1", 1'b0, 2'b00, 8'h3C, 1'b0);
        step(); exp_a("loser_grant", 1'b1, 2'b10, 8'h77, 1'b1); ifa.req = 2'b00;
        for (int i = 0; i < 4; i++) begin
            step(); exp_a("hold2", 1'b0, 2'b00, 8'h77, 1'b1);
        end
        step(); exp_a("idle2", 1'b0, 2'b00, 8'h77, 1'b0);

        // Single request with immediate re-request.
        ifa.wdata_in[15:8] = 8'hA5; ifa.req = 2'b10;
        step(); exp_a("single", 1'b1, 2'b10, 8'hA5, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(); exp_a("single_hold", 1'b0, 2'b00, 8'hA5, 1'b1);
        end
        step(); exp_a("single_idle", 1'b0, 2'b00, 8'hA5, 1'b0);
        step(); exp_a("rereq", 1'b1, 2'b10, 8'hA5, 1'b1); ifa.req = 2'b00;

        // Reset in the second HOLD cycle with req[0] pending.
        step(); exp_a("hold3a", 1'b0, 2'b00, 8'hA5, 1'b1);
        ifa.req = 2'b01; ifa.wdata_in[7:0] = 8'hC3;
        step(); exp_a("hold3b", 1'b0, 2'b00, 8'hA5, 1'b1); reset = 1'b1;
        step(); exp_a("rst_mid_hold", 1'b0, 2'b00, 8'h00, 1'b0); reset = 1'b0;
        step(); exp_a("post_rst_grant", 1'b1, 2'b01, 8'hC3, 1'b1); ifa.req = 2'b00;
        step(); exp_a("post_rst_hold", 1'b0, 2'b00, 8'hC3, 1'b1);

        for (int i = 0; i < 15; i++) begin
            string tag;
            step();
            tag = $sformatf("tbl%0d", i);
            chk_out(tag, ifb.WE, {2'b00, ifb.ack}, ifb.Wdata, ifb.busy,
                    vb[i].ewe, {2'b00, vb[i].eack}, vb[i].ewd, vb[i].ebusy);
            ifb.req      = vb[i].req;
            ifb.wdata_in = {8'h22, vb[i].wd0};
        end

        // Pointer wrap on a 4-requester arbiter.
        step(); exp_c("c_idle0", 1'b0, 4'b0000, 8'h00, 1'b0); ifc.req = 4'b0100;
        step(); exp_c("c_grant2", 1'b1, 4'b0100, 8'hC2, 1'b1); ifc.req = 4'b0000;
        step(); exp_c("c_hold2", 1'b0, 4'b0000, 8'hC2, 1'b1); ifc.req = 4'b1001;
        step(); exp_c("c_idle2", 1'b0, 4'b0000, 8'hC2, 1'b0);
        step(); exp_c("c_wrap1", 1'b1, g1_ack, g1_wd, 1'b1); ifc.req = after1;
        step(); exp_c("c_hold_w1", 1'b0, 4'b0000, g1_wd, 1'b1);
        step(); exp_c("c_idle_w1", 1'b0, 4'b0000, g1_wd, 1'b0);
        step(); exp_c("c_wrap2", 1'b1, g2_ack, g2_wd, 1'b1); ifc.req = 4'b0011;
        step(); exp_c("c_hold_w2", 1'b0, 4'b0000, g2_wd, 1'b1);
        step(); exp_c("c_idle_w2", 1'b0, 4'b0000, g2_wd, 1'b0);
        step(); exp_c("c_ptr_back", 1'b1, g3_ack, g3_wd, 1'b1); ifc.req = 4'b0000;
        step(); exp_c("c_hold_w3", 1'b0, 4'b0000, g3_wd, 1'b1);
        step(); exp_c("c_idle_w3", 1'b0, 4'b0000, g3_wd, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/output_arbiter.md
# output_arbiter

Shares the processor's output register between several requesters, such as the CPU store path and a debug/monitor port. Each requester presents a write request with a data word. The arbiter grants requests one at a time in round-robin order and issues a single-cycle write (WE, Wdata) to the output register. After each write it enforces a configurable hold period, so a displayed value stays visible before the next write can replace it.

## Interface
- WORD_W, 8: width of data word and of Wdata
- N_REQ, 2: number of requesters, legal range 2..8
- HOLD_CYCLES, 4: idle cycles enforced after each write, legal range 0..255
- clock  input  1  system clock, all state updates on posedge
- reset  input  1  synchronous, active-high reset
- req  input  N_REQ  write request, one bit per requester
- wdata_in  input  N_REQ*WORD_W  request data, flattened; requester i occupies bits [i*WORD_W +: WORD_W]
- ack  output  N_REQ  one-cycle grant/completion pulse to the winning requester
- WE  output  1  write enable to the output register
- Wdata  output  WORD_W  write data to the output register
- busy  output  1  high whenever the state is not IDLE

## Operation
- The state machine has three states: IDLE, WRITE and HOLD.
- IDLE:
  - If any req bit is high, select a winner, latch its index and its wdata_in slice, then go to WRITE.
  - If no req bit is high, stay in IDLE.
- Winner selection (round-robin):
  - Search from pointer ptr upward (ptr, ptr+1, …) and wrap past N_REQ-1 to 0.
  - The first requester found with req high wins.
- WRITE (exactly one cycle):
  - WE=1 and Wdata=latched data.
  - ack[winner]=1; all other ack bits are 0.
  - ptr ← winner+1, or 0 if winner = N_REQ-1.
  - Next state is HOLD if HOLD_CYCLES>0, otherwise IDLE.
  - On entry to HOLD, load the counter with HOLD_CYCLES-1.
- HOLD:
  - WE=0 and ack=0.
  - The counter decrements each cycle.
  - Go to IDLE in the cycle the counter reads 0. HOLD therefore lasts exactly HOLD_CYCLES cycles.
- req is sampled only in IDLE. Requests that arrive during WRITE or HOLD wait until the arbiter returns to IDLE.
- Wdata holds the last written value outside WRITE. WE is the only qualifier for the output register.
- Requester contract:
  - Hold req and wdata_in stable until ack is seen.
  - Drop req in the cycle after ack. If req is still high at the next IDLE, it counts as a new request.
- Counter width is 8 bits; ptr width is $clog2(N_REQ).

## Timing
- Reset values: state=IDLE, ptr=0, counter=0, latched data=0, WE=0, Wdata=0, ack=0, busy=0.
- Reset sampled high at an edge forces all of the reset values from that edge onward. This applies in any state; an in-progress WRITE or HOLD is abandoned and no WE pulse follows.
- Latency:
  - req is seen in IDLE in cycle t.
  - WE and ack are high in cycle t+1.
  - The output register updates at the end of t+1.
- busy is high from t+1 through t+1+HOLD_CYCLES.
- Minimum spacing between consecutive WE pulses is HOLD_CYCLES+2 cycles (WRITE, HOLD_CYCLES, IDLE).
- ack coincides exactly with WE. There is never more than one ack bit high.
- Simultaneous requests are resolved in the IDLE cycle by the selection rule. The losers get no ack and keep waiting.

## Configuration
- OUTARB_FIXED_PRIO_EN:
  - Defined: fixed priority, where the lowest-index requester with req high always wins. ptr is not implemented and is held at 0.
  - Undefined (default): round-robin as described above.

## Test plan
- Reset: hold reset high for 2 cycles with req=2'b11 → WE=0, Wdata=0, ack=0, busy=0 throughout; the first grant comes 2 cycles after reset falls (IDLE, then WRITE).
- Single request (N_REQ=2, HOLD_CYCLES=4): req[1]=1 with data 8'hA5 at cycle t → WE=1, ack=2'b10, Wdata=8'hA5 at t+1; busy high t+1..t+5; an immediate re-request is granted no earlier than t+7.
- Contention (HOLD_CYCLES=0): both requesters hold req, with data 8'h11 for requester 0 and 8'h22 for requester 1 → Wdata sequence 11, 22, 11, 22 on WE pulses every 2 cycles. With OUTARB_FIXED_PRIO_EN the sequence is 11, 11, 11.
- Wrap-around (N_REQ=4): after a grant to requester 2 (ptr=3), raise req[3] and req[0] → requester 3 is granted first, then requester 0; ptr returns to 1.
- Reset mid-HOLD (HOLD_CYCLES=4): assert reset in the second HOLD cycle while req[0] is pending → from the next edge state=IDLE, ptr=0 and no WE; req[0] is granted (WE=1) in the second cycle after reset falls.
- HOLD_CYCLES=0 stream: requester 0 drops req after each ack and re-raises it in the next cycle → one WE every 2 cycles, and busy is high only in WRITE cycles.
